// File: rtl/fetch_pc.sv
// Fetch program counter: next-PC selection, optional single branch delay slot,
// return-address stack with return-misprediction counter.
module fetch_pc #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter int unsigned RAS_DEPTH  = 4,
    parameter int unsigned DELAY_SLOT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [2:0]  kind,
    input  logic        cond,
    input  logic [15:0] imm16,
    input  logic [25:0] index26,
    input  logic [31:0] rs_val,
    output logic [31:0] pc,
    output logic [31:0] npc,
    output logic        link_we,
    output logic [31:0] link_addr,
    output logic [31:0] ras_top,
    output logic        ras_empty,
    output logic        ras_full,
    output logic [15:0] mispred_cnt,
    output logic        slot_err
);

    localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    localparam logic [2:0] K_SEQ  = 3'd0;
    localparam logic [2:0] K_BR   = 3'd1;
    localparam logic [2:0] K_BRL  = 3'd2;
    localparam logic [2:0] K_J    = 3'd3;
    localparam logic [2:0] K_JAL  = 3'd4;
    localparam logic [2:0] K_JR   = 3'd5;
    localparam logic [2:0] K_JALR = 3'd6;

    typedef enum logic {IDLE, SLOT} state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q;
    logic [31:0]   pend_q, pend_d;
    logic [31:0]   ras_q [RAS_DEPTH];
    logic [PW-1:0] sp_q;
    logic [CW-1:0] cnt_q;
    logic [15:0]   mis_q;

    logic [31:0]   p4, btgt, jtgt, target;
    logic [PW-1:0] top_idx;
    logic          taken, is_link, do_push, do_pop, is_ret;
    logic          in_slot, active, mispred;

    always_comb begin
        p4      = pc_q + 32'd4;
        btgt    = p4 + {{14{imm16[15]}}, imm16, 2'b00};
        jtgt    = {p4[31:28], index26, 2'b00};
        taken   = 1'b0;
        target  = p4;
        is_link = 1'b0;
        do_push = 1'b0;
        do_pop  = 1'b0;
        is_ret  = 1'b0;
        case (kind)
            K_BR:   begin taken = cond; target = btgt; end
            K_BRL:  begin taken = cond; target = btgt; is_link = cond; do_push = cond; end
            K_J:    begin taken = 1'b1; target = jtgt; end
            K_JAL:  begin taken = 1'b1; target = jtgt; is_link = 1'b1; do_push = 1'b1; end
            K_JR:   begin taken = 1'b1; target = rs_val; do_pop = 1'b1; is_ret = 1'b1; end
            K_JALR: begin
                taken = 1'b1; target = rs_val; is_link = 1'b1;
                do_push = 1'b1; do_pop = 1'b1; is_ret = 1'b1;
            end
            default: ;
        endcase

        in_slot   = (DELAY_SLOT != 0) && (state_q == SLOT);
        active    = !stall && !in_slot;
        link_we   = active && is_link;
        link_addr = (DELAY_SLOT != 0) ? pc_q + 32'd8 : p4;
        slot_err  = in_slot && (kind != K_SEQ) && (kind != 3'd7);

        // Without a delay slot the transfer is immediate; with one it is deferred via pend.
        state_d = IDLE;
        pend_d  = pend_q;
        if (in_slot) begin
            npc = pend_q;
        end else if (DELAY_SLOT == 0) begin
            npc = taken ? target : p4;
        end else begin
            npc = p4;
            if (taken) begin
                state_d = SLOT;
                pend_d  = target;
            end
        end

        top_idx   = sp_q - PW'(1);
        ras_empty = (cnt_q == '0);
        ras_full  = (cnt_q == CW'(RAS_DEPTH));
        ras_top   = ras_empty ? 32'd0 : ras_q[top_idx];
        mispred   = active && is_ret && (ras_empty || (ras_top != rs_val));
    end

    // sp_q points at the next free slot; the buffer wraps and overwrites the oldest entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            state_q <= IDLE;
            pend_q  <= 32'd0;
            sp_q    <= '0;
            cnt_q   <= '0;
            mis_q   <= 16'd0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= 32'd0;
        end else if (!stall) begin
            pc_q    <= npc;
            state_q <= state_d;
            pend_q  <= pend_d;
            if (active) begin
                if (do_push && do_pop) begin
                    if (ras_empty) begin
                        ras_q[sp_q] <= link_addr;
                        sp_q        <= sp_q + PW'(1);
                        cnt_q       <= CW'(1);
                    end else begin
                        ras_q[top_idx] <= link_addr;
                    end
                end else if (do_push) begin
                    ras_q[sp_q] <= link_addr;
                    sp_q        <= sp_q + PW'(1);
                    if (!ras_full) cnt_q <= cnt_q + CW'(1);
                end else if (do_pop && !ras_empty) begin
                    sp_q  <= top_idx;
                    cnt_q <= cnt_q - CW'(1);
                end
            end
            if (mispred && (mis_q != 16'hFFFF)) mis_q <= mis_q + 16'd1;
        end
    end

    assign pc          = pc_q;
    assign mispred_cnt = mis_q;

endmodule

// File: tb/tb_fetch_pc.sv
// Directed bench for fetch_pc: one instance without and one with a delay slot,
// sharing stimulus; expected values are hand-computed constants.
module tb_fetch_pc;

    logic        clk = 1'b0;
    logic        reset, stall, cond;
    logic [2:0]  kind;
    logic [15:0] imm16;
    logic [25:0] index26;
    logic [31:0] rs_val;

    logic [31:0] pc0, npc0, la0, top0;
    logic        lwe0, emp0, full0, serr0;
    logic [15:0] mis0;
    logic [31:0] pc1, npc1, la1, top1;
    logic        lwe1, emp1, full1, serr1;
    logic [15:0] mis1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_pc #(.DELAY_SLOT(0)) u_dut (
        .clk(clk), .reset(reset), .stall(stall), .kind(kind), .cond(cond),
        .imm16(imm16), .index26(index26), .rs_val(rs_val),
        .pc(pc0), .npc(npc0), .link_we(lwe0), .link_addr(la0),
        .ras_top(top0), .ras_empty(emp0), .ras_full(full0),
        .mispred_cnt(mis0), .slot_err(serr0)
    );

    fetch_pc #(.DELAY_SLOT(1)) u_ds (
        .clk(clk), .reset(reset), .stall(stall), .kind(kind), .cond(cond),
        .imm16(imm16), .index26(index26), .rs_val(rs_val),
        .pc(pc1), .npc(npc1), .link_we(lwe1), .link_addr(la1),
        .ras_top(top1), .ras_empty(emp1), .ras_full(full1),
        .mispred_cnt(mis1), .slot_err(serr1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; stall = 1'b0; kind = 3'd0; cond = 1'b0;
        imm16 = 16'd0; index26 = 26'd0; rs_val = 32'd0;
        #3;
        check("rst_pc_async", pc0, 32'h3000);
        check("rst_empty", 32'(emp0), 32'd1);
        check("rst_full", 32'(full0), 32'd0);
        check("rst_top", top0, 32'd0);
        check("rst_mis", 32'(mis0), 32'd0);
        step();
        check("rst_pc_held", pc0, 32'h3000);
        reset = 1'b0;

        // three SEQ cycles
        check("seq_npc", npc0, 32'h3004);
        step(); check("seq_pc1", pc0, 32'h3004);
        step(); check("seq_pc2", pc0, 32'h3008);
        step(); check("seq_pc3", pc0, 32'h300C);
        step(); check("seq_pc4", pc0, 32'h3010);

        // backward branch from 0x3010
        kind = 3'd1; imm16 = 16'hFFFC; cond = 1'b1; #1;
        check("br_taken_npc", npc0, 32'h3004);
        check("br_no_link", 32'(lwe0), 32'd0);
        cond = 1'b0; #1;
        check("br_nt_npc", npc0, 32'h3014);
        check("br_nt_no_link", 32'(lwe0), 32'd0);
        kind = 3'd2; cond = 1'b1; #1;
        check("brl_link_we", 32'(lwe0), 32'd1);
        check("brl_link_addr", la0, 32'h3014);
        kind = 3'd0; cond = 1'b0;

        // JAL then matching JR
        pulse_reset();
        kind = 3'd4; index26 = 26'h0000100; #1;
        check("jal_npc", npc0, 32'h400);
        check("jal_link_we", 32'(lwe0), 32'd1);
        check("jal_link_addr", la0, 32'h3004);
        step();
        check("jal_pc", pc0, 32'h400);
        check("jal_top", top0, 32'h3004);
        check("jal_nonempty", 32'(emp0), 32'd0);
        kind = 3'd5; rs_val = 32'h3004; #1;
        check("jr_npc", npc0, 32'h3004);
        step();
        check("jr_pc", pc0, 32'h3004);
        check("jr_empty", 32'(emp0), 32'd1);
        check("jr_mis", 32'(mis0), 32'd0);

        // stall during JAL
        kind = 3'd4; stall = 1'b1; #1;
        check("stall_no_link", 32'(lwe0), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", pc0, 32'h3004);
            check("stall_empty", 32'(emp0), 32'd1);
        end
        stall = 1'b0; #1;
        check("unstall_link_we", 32'(lwe0), 32'd1);
        check("unstall_link_addr", la0, 32'h3008);
        step();
        check("unstall_pc", pc0, 32'h400);
        check("unstall_top", top0, 32'h3008);

        // five JALs overflow the 4-entry stack, five JRs drain it
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            kind = 3'd4; index26 = 26'h100 + 26'(i);
            step();
            check("ovf_pc", pc0, 32'h400 + 32'(4 * i));
        end
        check("ovf_full", 32'(full0), 32'd1);
        check("ovf_top", top0, 32'h410);
        for (int i = 0; i < 4; i++) begin
            kind = 3'd5; rs_val = 32'h410 - 32'(4 * i); #1;
            check("drain_top", top0, rs_val);
            step();
            check("drain_mis", 32'(mis0), 32'd0);
        end
        check("drain_empty", 32'(emp0), 32'd1);
        rs_val = 32'h3004;
        step();
        check("drain_5th_mis", 32'(mis0), 32'd1);
        check("drain_5th_pc", pc0, 32'h3004);

        // JALR on empty stack pushes one entry
        kind = 3'd6; rs_val = 32'h500; #1;
        check("jalr_link_addr", la0, 32'h3008);
        step();
        check("jalr_pc", pc0, 32'h500);
        check("jalr_top", top0, 32'h3008);
        check("jalr_mis", 32'(mis0), 32'd2);
        check("jalr_not_full", 32'(full0), 32'd0);

        // delay slot instance
        pulse_reset();
        check("ds_pc0", pc1, 32'h3000);
        kind = 3'd3; index26 = 26'h100; #1;
        check("ds_j_npc", npc1, 32'h3004);
        check("ds_j_serr", 32'(serr1), 32'd0);
        step();
        check("ds_slot_pc", pc1, 32'h3004);
        kind = 3'd2; cond = 1'b1; #1;
        check("ds_slot_npc", npc1, 32'h400);
        check("ds_slot_err", 32'(serr1), 32'd1);
        check("ds_slot_no_link", 32'(lwe1), 32'd0);
        step();
        check("ds_tgt_pc", pc1, 32'h400);
        kind = 3'd4; cond = 1'b0; #1;
        check("ds_serr_clear", 32'(serr1), 32'd0);
        check("ds_link_addr", la1, 32'h408);

        // reset mid-slot discards the pending target
        kind = 3'd3; index26 = 26'h100;
        step();
        check("ds_slot2_pc", pc1, 32'h404);
        kind = 3'd0;
        reset = 1'b1; #1;
        check("ds_midslot_rst_pc", pc1, 32'h3000);
        reset = 1'b0;
        step();
        check("ds_after_rst_pc", pc1, 32'h3004);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
